// File: rtl/gearbox_push_arbiter.sv
// Round-robin push-side arbiter: one producer owns the gearbox write port for a whole output word.
// Optional stall timeout with zero padding is enabled by defining GEARBOX_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module gearbox_push_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDATA_WIDTH    = 16,
  parameter int ODATA_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int BEAT_NUM = (ODATA_WIDTH + IDATA_WIDTH - 1) / IDATA_WIDTH,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic [NUM_REQ*IDATA_WIDTH-1:0] req_data_in,
  output logic                           fifo_push_req_out,
  output logic [IDATA_WIDTH-1:0]         fifo_data_out,
  input  logic                           fifo_full_in,
  output logic                           grant_valid_out,
  output logic [ID_W-1:0]                grant_id_out,
  output logic [CNT_W-1:0]               beat_cnt_out,
  output logic                           pad_pulse_out
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("gearbox_push_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]        owner, owner_nxt;
  logic [CNT_W-1:0]       beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]        winner;
  logic                   any_valid;
  logic                   transfer;
  logic                   padding;
  logic                   last_beat;
  logic [IDATA_WIDTH-1:0] owner_data;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid_in[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

  assign owner_data = req_data_in[int'(owner)*IDATA_WIDTH +: IDATA_WIDTH];
  assign last_beat  = (beat_cnt == CNT_W'(BEAT_NUM - 1));

  // Ready/push/data are forwarded combinationally from the registered owner.
  always_comb begin
    req_ready_out     = '0;
    transfer          = 1'b0;
    pad_pulse_out     = 1'b0;
    fifo_push_req_out = 1'b0;
    fifo_data_out     = '0;
    if (state == BURST) begin
      if (!padding) begin
        req_ready_out[owner] = ~fifo_full_in;
        transfer             = req_valid_in[owner] & ~fifo_full_in;
      end
      pad_pulse_out     = padding & ~fifo_full_in;
      fifo_push_req_out = transfer | pad_pulse_out;
      if (transfer) fifo_data_out = owner_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = BURST;
          owner_nxt = winner;
        end
      end
      BURST: begin
        if (fifo_push_req_out) begin
          if (last_beat) begin
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

`ifdef GEARBOX_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall;

  assign stall = ~padding & (beat_cnt != '0) & ~req_valid_in[owner] & ~fifo_full_in;

  // Once the limit is hit, padding owns the word until its last beat is pushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      padding   <= 1'b0;
    end else if (state == BURST) begin
      if (transfer) begin
        stall_cnt <= '0;
      end else if (stall) begin
        if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          stall_cnt <= '0;
          padding   <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
      if (pad_pulse_out && last_beat) padding <= 1'b0;
    end else begin
      stall_cnt <= '0;
      padding   <= 1'b0;
    end
  end
`else
  assign padding = 1'b0;
`endif

  assign grant_valid_out = (state == BURST);
  assign grant_id_out    = owner;
  assign beat_cnt_out    = beat_cnt;

endmodule

// File: doc/gearbox_push_arbiter.md
# gearbox_push_arbiter

Round-robin push-side arbiter sharing one gearbox FIFO write port among NUM_REQ narrow-word producers. A grant is held for exactly one output word (BEAT_NUM input beats), so beats of different producers never interleave within a gearbox output word. Sits directly in front of the gearbox FIFO push port; the pop side is untouched.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- IDATA_WIDTH, 16, producer beat width; equals gearbox input width
- ODATA_WIDTH, 64, gearbox output width; BEAT_NUM = ceil(ODATA_WIDTH/IDATA_WIDTH)
- TIMEOUT_CYCLES, 16, stall limit; used only with the macro in Configuration

- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- req_valid_in  in  NUM_REQ  per-producer beat valid
- req_ready_out  out  NUM_REQ  per-producer beat accept
- req_data_in  in  NUM_REQ x IDATA_WIDTH  per-producer beat data
- fifo_push_req_out  out  1  gearbox push request
- fifo_data_out  out  IDATA_WIDTH  gearbox push data
- fifo_full_in  in  1  gearbox full (for the FIFO lane currently selected)
- grant_valid_out  out  1  a producer currently owns the port
- grant_id_out  out  clog2(NUM_REQ) (min 1)  current owner index
- beat_cnt_out  out  clog2(BEAT_NUM) (min 1)  beats accepted in current word
- pad_pulse_out  out  1  one-cycle pulse per padded beat (macro only; else tied 0)

## Operation
- States: IDLE, BURST. Reset: IDLE, rr_ptr=0, beat_cnt=0, owner=0; all outputs 0.
- IDLE: if any req_valid_in set, choose first valid index starting at rr_ptr, wrapping at NUM_REQ; next cycle state=BURST, owner=winner, grant_valid_out=1. No beat accepted in IDLE.
- BURST: req_ready_out[owner] = ~fifo_full_in; all other ready bits 0. Transfer = req_valid_in[owner] & req_ready_out[owner]. fifo_push_req_out = transfer; fifo_data_out = req_data_in[owner] (combinational mux, zero when no transfer).
- Each transfer increments beat_cnt; on transfer with beat_cnt==BEAT_NUM-1: beat_cnt=0, rr_ptr=owner+1 (wrap NUM_REQ-1 -> 0), state=IDLE.
- Owner dropping valid mid-word: lock held, no push, beat_cnt frozen (unless timeout macro).
- fifo_full_in high: no push; beat stays pending at producer; lock held.
- Valid from non-owners ignored; they wait for IDLE.
- beat_cnt tracks the gearbox lane pointer; both reset together, and the gearbox is pushed only by this block, so they stay aligned.
- BEAT_NUM==1: every word is one beat; arbitration each word.

## Timing
- Arbitration: 1 cycle IDLE per word; max throughput BEAT_NUM beats per BEAT_NUM+1 cycles.
- Ready/push/data: combinational from registered state plus fifo_full_in and req_valid_in (zero-latency forwarding).
- grant_valid_out, grant_id_out, beat_cnt_out: registered.
- Same-cycle final beat and new requests: state returns to IDLE; new winner granted the following cycle using the updated rr_ptr.
- Reset mid-burst: immediate return to reset values; partial word is discarded upstream only if the gearbox is reset together (required at system level).

## Configuration
- GEARBOX_ARB_TIMEOUT_EN defined: in BURST, a stall counter counts cycles with beat_cnt!=0, req_valid_in[owner]=0, fifo_full_in=0; reset on any transfer. At TIMEOUT_CYCLES, the block pushes zero beats (one per cycle while not full, pad_pulse_out=1 each) until the word completes, then IDLE with normal rr_ptr update. Owner ready is 0 while padding.
- Undefined: no stall counter; lock held indefinitely; pad_pulse_out=0.

## Test plan
- Single producer 1, BEAT_NUM=4, data 0x1111..0x4444 back-to-back, full=0 -> 1 IDLE cycle, then 4 consecutive pushes of 0x1111..0x4444, grant_id_out=1, return to IDLE.
- All 4 producers valid continuously -> word order 0,1,2,3,0; each word's 4 beats contiguous from one producer, no interleave.
- fifo_full_in high for 3 cycles at beat 2 of producer 2 -> ready low, no push for 3 cycles, beat 2 pushed on first non-full cycle, beat_cnt continues 2->3.
- Owner 3 drops valid after beat 1 while producer 0 valid -> producer 0 not granted until owner 3 finishes; rr_ptr wraps to 0 afterward.
- Macro on, TIMEOUT_CYCLES=16, owner stops after beat 1 -> after 16 idle cycles, 2 zero beats pushed with 2 pad pulses, then IDLE.
- Assert rstn low mid-burst at beat 2 -> all outputs 0 immediately; after release, next grant starts at producer 0 with beat_cnt=0.
